// File: rtl/nmac_pkt_pkg.sv
// Shared types and constants for the ingress-port arbiter: packet word width,
// word-type codes and the scheduler state encoding.
package nmac_pkt_pkg;

  localparam int PKT_W     = 139;
  localparam int MAX_PORTS = 8;
  localparam int GRANT_W   = 3;

  localparam logic [2:0] TYPE_HDR  = 3'b101;
  localparam logic [2:0] TYPE_MID  = 3'b100;
  localparam logic [2:0] TYPE_TAIL = 3'b110;
  localparam logic [2:0] TYPE_ONE  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DROP = 2'd2
  } state_t;

  function automatic logic is_last_word(input logic [2:0] t);
    return (t == TYPE_TAIL) || (t == TYPE_ONE);
  endfunction

endpackage

// File: rtl/nmac_rr_picker.sv
// Rotate-priority picker: first requesting port after rr_ptr, wrapping at NUM_PORTS.
module nmac_rr_picker
  import nmac_pkt_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [GRANT_W-1:0]   rr_ptr,
  output logic                 found,
  output logic [GRANT_W-1:0]   sel
);

  // Zero-extended so any 3-bit index is in range regardless of NUM_PORTS.
  logic [MAX_PORTS-1:0] req_ext;
  assign req_ext = MAX_PORTS'(req);

  // Walk from farthest to nearest so the nearest requester after rr_ptr wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      if (req_ext[GRANT_W'((int'(rr_ptr) + i) % NUM_PORTS)]) begin
        found = 1'b1;
        sel   = GRANT_W'((int'(rr_ptr) + i) % NUM_PORTS);
      end
    end
  end

endmodule

// File: rtl/nmac_port_arbiter.sv
// Round-robin merge of CRC-checked ingress packet FIFOs into one output stream;
// good packets are forwarded whole, bad ones drained and counted per port.
module nmac_port_arbiter
  import nmac_pkt_pkg::*;
#(
  parameter int         NUM_PORTS   = 4,
  parameter logic [7:0] FULL_THRESH = 8'd161,
  parameter int         CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_PORTS*PKT_W-1:0] in_pkt_q,
  output logic [NUM_PORTS-1:0]       in_pkt_rdreq,
  input  logic [NUM_PORTS-1:0]       in_valid_q,
  input  logic [NUM_PORTS-1:0]       in_valid_empty,
  output logic [NUM_PORTS-1:0]       in_valid_rdreq,
  input  logic [7:0]                 out_pkt_usedw,
  output logic                       out_pkt_wrreq,
  output logic [PKT_W-1:0]           out_pkt,
  output logic                       out_valid_wrreq,
  output logic                       out_valid,
  output logic [GRANT_W-1:0]         grant,
  output logic                       busy,
  output logic                       framing_err,
  output logic [NUM_PORTS*CNT_W-1:0] drop_cnt
);

  state_t                          state, next_state;
  logic [GRANT_W-1:0]              rr_ptr, pick_sel;
  logic                            pick_found, start, first_word;
  logic [PKT_W-1:0]                heads [MAX_PORTS];
  logic [PKT_W-1:0]                head;
  logic [2:0]                      head_type;
  logic                            tail_hit;
  logic [MAX_PORTS-1:0]            valid_ext;
  logic [NUM_PORTS-1:0][CNT_W-1:0] cnt_q;

  for (genvar p = 0; p < MAX_PORTS; p++) begin : g_head
    if (p < NUM_PORTS) begin : g_live
      assign heads[p] = in_pkt_q[p*PKT_W +: PKT_W];
    end else begin : g_pad
      assign heads[p] = '0;
    end
  end

  assign valid_ext = MAX_PORTS'(in_valid_q);
  assign head      = heads[grant];
  assign head_type = head[PKT_W-1 -: 3];
  assign tail_hit  = is_last_word(head_type);
  assign drop_cnt  = cnt_q;

  nmac_rr_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .req    (~in_valid_empty),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .sel    (pick_sel)
  );

  // A verdict implies the whole packet is resident, so the only gate is downstream headroom.
  assign start = (state == IDLE) && pick_found && (out_pkt_usedw < FULL_THRESH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:       if (start) next_state = valid_ext[pick_sel] ? SEND : DROP;
      SEND, DROP: if (tail_hit) next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  always_comb begin
    in_pkt_rdreq   = '0;
    in_valid_rdreq = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      in_pkt_rdreq[p]   = (state != IDLE) && (grant == GRANT_W'(p));
      in_valid_rdreq[p] = start && (pick_sel == GRANT_W'(p));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_pkt_wrreq   <= 1'b0;
      out_pkt         <= '0;
      out_valid_wrreq <= 1'b0;
      out_valid       <= 1'b0;
      grant           <= '0;
      rr_ptr          <= GRANT_W'(NUM_PORTS - 1);
      busy            <= 1'b0;
      framing_err     <= 1'b0;
      first_word      <= 1'b0;
      cnt_q           <= '0;
    end else begin
      out_pkt_wrreq   <= 1'b0;
      out_valid_wrreq <= 1'b0;
      out_valid       <= 1'b0;
      busy            <= (next_state != IDLE);
      if (start) begin
        grant      <= pick_sel;
        rr_ptr     <= pick_sel;
        first_word <= 1'b1;
      end
      if (state == SEND) begin
        out_pkt       <= head;
        out_pkt_wrreq <= 1'b1;
        first_word    <= 1'b0;
        if (!first_word && head_type == TYPE_HDR) framing_err <= 1'b1;
        if (tail_hit) begin
          out_valid_wrreq <= 1'b1;
          out_valid       <= 1'b1;
        end
      end
      if (state == DROP) first_word <= 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (state == DROP && tail_hit && grant == GRANT_W'(p) && cnt_q[p] != '1)
          cnt_q[p] <= cnt_q[p] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nmac_port_arbiter.sv
// Scoreboard bench: modelled ingress FIFOs feed the arbiter, expected output words
// are queued at load time and a forked monitor checks every write against them.
module tb_nmac_port_arbiter;

  localparam int NP = 4;
  localparam int CW = 4;   // narrow counter so saturation is reachable quickly
  localparam int W  = 139;

  typedef struct {
    logic [W-1:0] w;
    bit           last;
    logic [2:0]   g;
    int           gap;     // expected cycles since previous write, 0 = unchecked
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NP*W-1:0]   in_pkt_q;
  logic [NP-1:0]     in_pkt_rdreq, in_valid_q, in_valid_empty, in_valid_rdreq;
  logic [7:0]        out_pkt_usedw;
  logic              out_pkt_wrreq, out_valid_wrreq, out_valid, busy, framing_err;
  logic [W-1:0]      out_pkt;
  logic [2:0]        grant;
  logic [NP*CW-1:0]  drop_cnt;

  logic [W-1:0] pq [NP][$];
  bit           vq [NP][$];
  exp_t         exp_q [$];
  int           pops_pkt [NP];
  int           pops_vld [NP];
  int           cyc = 0, tag = 0;
  int           n_checks = 0, n_pass = 0;

  nmac_port_arbiter #(.NUM_PORTS(NP), .FULL_THRESH(8'd161), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .in_pkt_q(in_pkt_q), .in_pkt_rdreq(in_pkt_rdreq),
    .in_valid_q(in_valid_q), .in_valid_empty(in_valid_empty), .in_valid_rdreq(in_valid_rdreq),
    .out_pkt_usedw(out_pkt_usedw), .out_pkt_wrreq(out_pkt_wrreq), .out_pkt(out_pkt),
    .out_valid_wrreq(out_valid_wrreq), .out_valid(out_valid),
    .grant(grant), .busy(busy), .framing_err(framing_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
  endtask

  task automatic flag(input string nm);
    n_checks++;
    $display("FAIL %s: got event expected none (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [W-1:0] mk(input logic [2:0] t, input int n);
    return {t, 8'hA5, 128'(n)};
  endfunction

  function automatic logic [CW-1:0] dc(input int p);
    return drop_cnt[p*CW +: CW];
  endfunction

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      in_pkt_q[p*W +: W] = (pq[p].size() != 0) ? pq[p][0] : '0;
      in_valid_empty[p]  = (vq[p].size() == 0);
      in_valid_q[p]      = (vq[p].size() != 0) ? vq[p][0] : 1'b0;
    end
  endtask

  // One clock: sample the pop requests, then pop the modelled FIFOs after the edge.
  task automatic tick();
    logic [NP-1:0] rp, rv;
    @(negedge clk);
    rp = in_pkt_rdreq;
    rv = in_valid_rdreq;
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < NP; p++) begin
      if (rp[p]) begin
        if (pq[p].size() == 0) flag("pkt_pop_empty");
        else begin void'(pq[p].pop_front()); pops_pkt[p]++; end
      end
      if (rv[p]) begin
        if (vq[p].size() == 0) flag("vld_pop_empty");
        else begin void'(vq[p].pop_front()); pops_vld[p]++; end
      end
    end
    drive();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // typs holds word types, first word in the low 3 bits; only the first n_exp words are expected out.
  task automatic load_pkt(input int p, input bit good, input int n, input logic [23:0] typs,
                          input int first_gap, input int n_exp);
    logic [W-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = mk(typs[i*3 +: 3], tag++);
      pq[p].push_back(w);
      if (good && i < n_exp)
        exp_q.push_back('{w: w, last: (i == n - 1), g: 3'(p), gap: (i == 0) ? first_gap : 1});
    end
    vq[p].push_back(good);
    drive();
  endtask

  task automatic drain(input string nm, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    chk(nm, W'(exp_q.size()), W'(0));
  endtask

  task automatic monitor();
    exp_t e;
    int   last_cyc = -100;
    forever begin
      @(negedge clk);
      if (out_valid_wrreq && !out_pkt_wrreq) flag("valid_without_word");
      if (out_pkt_wrreq) begin
        if (exp_q.size() == 0) flag("unexpected_write");
        else begin
          e = exp_q.pop_front();
          chk("out_pkt", out_pkt, e.w);
          chk("out_valid_wrreq", W'(out_valid_wrreq), W'(e.last));
          chk("grant", W'(grant), W'(e.g));
          if (e.last) chk("out_valid", W'(out_valid), W'(1));
          if (e.gap != 0) chk("write_gap", W'(cyc - last_cyc), W'(e.gap));
        end
        last_cyc = cyc;
      end
    end
  endtask

  initial begin
    int p0;
    out_pkt_usedw = 8'd0;
    for (int p = 0; p < NP; p++) begin pops_pkt[p] = 0; pops_vld[p] = 0; end
    drive();
    fork monitor(); join_none

    // reset state
    ticks(3);
    chk("rst_wrreq", W'(out_pkt_wrreq), W'(0));
    chk("rst_vwrreq", W'(out_valid_wrreq), W'(0));
    chk("rst_out_pkt", out_pkt, W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_grant", W'(grant), W'(0));
    chk("rst_ferr", W'(framing_err), W'(0));
    chk("rst_drop_cnt", W'(drop_cnt), W'(0));
    chk("rst_rdreq", W'({in_pkt_rdreq, in_valid_rdreq}), W'(0));
    reset = 1'b1;
    ticks(2);

    // two good packets on port 0: consecutive words, tail strobe, one idle cycle between
    load_pkt(0, 1'b1, 3, 24'({3'b110, 3'b100, 3'b101}), 0, 3);
    load_pkt(0, 1'b1, 2, 24'({3'b110, 3'b101}), 2, 2);
    drain("drain_port0", 30);
    ticks(2);
    chk("ferr_clean", W'(framing_err), W'(0));

    // bad 4-word packet on port 2: drained silently, counted once
    p0 = pops_pkt[2];
    load_pkt(2, 1'b0, 4, 24'({3'b110, 3'b100, 3'b100, 3'b101}), 0, 0);
    ticks(8);
    chk("drop_pops", W'(pops_pkt[2] - p0), W'(4));
    chk("drop_cnt2_1", W'(dc(2)), W'(1));
    chk("drop_cnt0_0", W'(dc(0)), W'(0));

    // saturate port 2 counter
    for (int i = 0; i < 14; i++) load_pkt(2, 1'b0, 1, 24'(3'b111), 0, 0);
    ticks(34);
    chk("drop_cnt2_max", W'(dc(2)), W'({CW{1'b1}}));
    p0 = pops_pkt[2];
    load_pkt(2, 1'b0, 1, 24'(3'b111), 0, 0);
    ticks(4);
    chk("drop_sat_pop", W'(pops_pkt[2] - p0), W'(1));
    chk("drop_cnt2_sat", W'(dc(2)), W'({CW{1'b1}}));

    // header seen mid-packet on port 3: still forwarded, sticky error
    load_pkt(3, 1'b1, 4, 24'({3'b110, 3'b101, 3'b100, 3'b101}), 0, 4);
    drain("drain_framing", 20);
    ticks(1);
    chk("ferr_set", W'(framing_err), W'(1));

    // fairness: two single-word packets per port, grants 0,1,2,3,0,1,2,3
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < NP; p++)
        load_pkt(p, 1'b1, 1, 24'(3'b111), (k == 0 && p == 0) ? 0 : 2, 1);
    drain("drain_fair", 40);
    ticks(2);
    chk("ferr_sticky", W'(framing_err), W'(1));

    // downstream full: no decision until usedw drops below threshold
    out_pkt_usedw = 8'd161;
    p0 = pops_vld[0];
    load_pkt(0, 1'b1, 1, 24'(3'b111), 0, 1);
    ticks(10);
    chk("full_no_pop", W'(pops_vld[0] - p0), W'(0));
    chk("full_busy", W'(busy), W'(0));
    chk("full_grant_hold", W'(grant), W'(3));
    out_pkt_usedw = 8'd160;
    tick();
    chk("thr_grant", W'(grant), W'(0));
    chk("thr_busy", W'(busy), W'(1));
    chk("thr_vpop", W'(pops_vld[0] - p0), W'(1));
    drain("drain_thr", 10);
    out_pkt_usedw = 8'd0;
    ticks(2);

    // reset mid-SEND on a 5-word packet from port 1
    load_pkt(1, 1'b1, 5, 24'({3'b110, 3'b100, 3'b100, 3'b100, 3'b101}), 0, 2);
    drain("drain_pre_reset", 20);
    chk("pre_rst_wrreq", W'(out_pkt_wrreq), W'(1));
    reset = 1'b0;
    #1;
    chk("arst_wrreq", W'(out_pkt_wrreq), W'(0));
    chk("arst_out_pkt", out_pkt, W'(0));
    chk("arst_busy", W'(busy), W'(0));
    chk("arst_grant", W'(grant), W'(0));
    chk("arst_drop_cnt", W'(drop_cnt), W'(0));
    chk("arst_ferr", W'(framing_err), W'(0));
    chk("arst_rdreq", W'(in_pkt_rdreq), W'(0));
    ticks(2);
    reset = 1'b1;
    p0 = pops_pkt[1];
    ticks(10);
    chk("post_rst_pops", W'(pops_pkt[1] - p0), W'(0));
    chk("post_rst_busy", W'(busy), W'(0));
    chk("exp_empty", W'(exp_q.size()), W'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nmac_port_arbiter.md
Name: nmac_port_arbiter

Overview:
- Round-robin scheduler that merges NUM_PORTS CRC-checked ingress streams into one 139-bit packet stream toward the forwarding FIFO.
- Each port presents a show-ahead packet FIFO (139-bit words) and a 1-bit per-packet verdict FIFO. A verdict is written only after its packet's tail is written.
- Good packets are forwarded whole. Bad packets are drained and counted.
- Output is throttled by the downstream FIFO fill level.

Parameters:
- NUM_PORTS, 4, number of ingress ports (2..8).
- FULL_THRESH, 8'd161, start a new packet only when out_pkt_usedw < FULL_THRESH.
- CNT_W, 16, width of each per-port drop counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- in_pkt_q  in  NUM_PORTS*139  show-ahead packet FIFO heads; port p occupies bits [p*139+138 : p*139]
- in_pkt_rdreq  out  NUM_PORTS  pop one word from port p's packet FIFO
- in_valid_q  in  NUM_PORTS  verdict FIFO heads (1 = CRC good)
- in_valid_empty  in  NUM_PORTS  verdict FIFO empty flags
- in_valid_rdreq  out  NUM_PORTS  pop one verdict from port p
- out_pkt_usedw  in  8  downstream packet FIFO fill level
- out_pkt_wrreq  out  1  write strobe for out_pkt
- out_pkt  out  139  forwarded word, unmodified
- out_valid_wrreq  out  1  one pulse per forwarded packet
- out_valid  out  1  always 1 when out_valid_wrreq is asserted
- grant  out  3  index of the port currently served
- busy  out  1  high in SEND or DROP
- framing_err  out  1  sticky; set on a header word seen mid-packet
- drop_cnt  out  NUM_PORTS*CNT_W  per-port saturating count of dropped packets

Behaviour:
- Word type field is bits [138:136]:
  - 101 = header
  - 100 = middle
  - 110 = tail
  - 111 = single-word packet (header and tail)
- Reset values: all outputs 0, state IDLE, rr_ptr = NUM_PORTS-1. Reset is asynchronous and may occur mid-packet; the partial packet is abandoned and nothing more is output for it.
- in_pkt_rdreq and in_valid_rdreq are combinational from state, grant and current head. All other outputs are registered.
- A port is eligible when its in_valid_empty is 0. Because a verdict exists, its whole packet is already resident in the packet FIFO.
- State IDLE:
  - Condition to start: out_pkt_usedw < FULL_THRESH and at least one port eligible.
  - Selection: pick the first eligible port, searching rr_ptr+1, rr_ptr+2, ... with wrap at NUM_PORTS.
  - On selection: register grant, set rr_ptr = selected port, pulse in_valid_rdreq[sel] for this cycle only.
  - Next state: SEND if in_valid_q[sel] = 1, else DROP.
  - out_pkt_wrreq = 0 and out_valid_wrreq = 0 while in IDLE.
- State SEND:
  - Every cycle: in_pkt_rdreq[grant] = 1; register out_pkt = head word and out_pkt_wrreq = 1.
  - On a 110 or 111 head: also register out_valid_wrreq = 1 and out_valid = 1 in the same cycle as the tail write, then go to IDLE.
  - A 101 head after the first word sets framing_err and is still forwarded.
  - There is no backpressure mid-packet; FULL_THRESH reserves the headroom.
- State DROP:
  - Every cycle: in_pkt_rdreq[grant] = 1; no output writes.
  - On a 110 or 111 head: increment drop_cnt[grant] (saturating at all-ones), then go to IDLE.
- Timing:
  - Decision cycle to first pop: 1 cycle.
  - Pop to out_pkt write: 1 cycle.
  - Gap between back-to-back packets: exactly 1 idle cycle.
- Fairness: with all ports continuously eligible, grants rotate 0,1,2,3,0,... and each packet is served to completion.
- A port whose verdict FIFO stays empty is skipped without stalling the others.
- An out_pkt_usedw change mid-packet has no effect.
- grant holds its last value while in IDLE.

Decomposition:
- Package nmac_pkt_pkg:
  - PKT_W = 139
  - Type codes TYPE_HDR = 3'b101, TYPE_MID = 3'b100, TYPE_TAIL = 3'b110, TYPE_ONE = 3'b111
  - State encoding IDLE / SEND / DROP
- Sub-module nmac_rr_picker: combinational rotate-priority pick.
  - Inputs: req[NUM_PORTS-1:0], rr_ptr.
  - Outputs: found, sel index.

Test Plan:
- Reset mid-SEND on a 5-word packet from port 1: all outputs 0 immediately; after release, no further words of that packet are written.
- Port 0 holds good 3-word packet (101, 100, 110):
  - out_pkt equals the 3 words in order on consecutive cycles.
  - out_valid_wrreq = 1 coincides with the tail write.
  - Exactly 1 idle cycle follows.
- Port 2 holds bad 4-word packet:
  - Zero output writes; in_pkt_rdreq[2] high for 4 cycles.
  - drop_cnt[2] goes 0 to 1.
  - drop_cnt[2] preset to 16'hFFFF stays at FFFF after another drop.
- All 4 ports each hold 2 single-word (111) good packets: grant sequence 0,1,2,3,0,1,2,3; 8 out_valid pulses.
- out_pkt_usedw = 161 with port 0 eligible: no grant, no pops. Drop usedw to 160: grant 0 next cycle.
- Port 3 good packet 101, 100, 101, 110: all 4 words forwarded; framing_err = 1 and stays set.
